decap_packet: RTL
=================

// Module: decap_packet
// PURPOSE
//  Receive-side counterpart of the port-0 encapsulator: consumes 64-bit Aurora words {payload[54:0], header[8:0]}.
//  Strips the header, reassembles up to NUMBER_PACKET 55-bit payload chunks LSB-first into one DATA_DFX_WIDTH word.
//  Presents the word with its header as a single-cycle valid pulse to the router core.
//  No backpressure: the upstream link cannot stall, so the block accepts a beat on every cycle with data_valid=1.
// PARAMETERS
//  DATA_WIDTH         1024  payload data bits of a DFX word
//  ADDR_WIDTH         10    address bits appended to a DFX word
//  DATA_DFX_WIDTH     1034  DATA_WIDTH+ADDR_WIDTH, reassembled width
//  NUMBER_PACKET      19    max beats per packet (ceil(1034/55))
//  HEADER_WIDTH       9     header bits: [1:0] router id, [6:2] packet id, [8:7] TTL
//  AURORA_DATA_WIDTH  64    link word width
//  PAYLOAD_WIDTH      55    AURORA_DATA_WIDTH-HEADER_WIDTH
//  CNT_WIDTH          16    width of delivered-packet counter
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     reset, asynchronous, active-low
//  data_in         in   64    link word {payload, header}
//  data_valid      in   1     data_in holds a beat this cycle
//  data_dfx_recv   out  1034  reassembled DFX word
//  header_recv     out  9     header latched from first beat of packet
//  beat_cnt_recv   out  5     number of beats in delivered packet (1..19)
//  recv_valid      out  1     1-cycle pulse: data_dfx_recv/header_recv/beat_cnt_recv valid
//  hdr_err         out  1     1-cycle pulse: header mismatch inside packet (macro only, else tied 0)
//  pkt_count       out  CNT_WIDTH  packets delivered since reset, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset: all outputs 0, assembly register 0, beat counter 0, state IDLE. Reset mid-packet discards the partial packet.
//  - FSM states: IDLE, COLLECT.
//  - IDLE + data_valid: clear assembly, write chunk 0 to bits [54:0], latch header, beat_cnt=1, go to COLLECT.
//  - COLLECT + data_valid: write chunk k to bits [55k+54:55k], beat_cnt++.
//    Bits beyond DATA_DFX_WIDTH-1 are dropped; beat 19 contributes only its payload[43:0].
//  - End of packet, case 1: COLLECT samples data_valid=0. At that edge, load outputs from assembly, recv_valid=1, go to IDLE.
//  - End of packet, case 2: the edge sampling beat NUMBER_PACKET merges that chunk directly into the outputs.
//    At the same edge recv_valid=1 and state goes to IDLE. A data_valid beat on the next cycle starts a new packet
//    (back-to-back packets with zero gap are supported).
//  - Latency: recv_valid rises at the edge after the last beat (short packet), or at the edge sampling beat 19.
//  - Outputs data_dfx_recv/header_recv/beat_cnt_recv hold their value until the next delivery. recv_valid is never high 2 cycles in a row unless two packets end back-to-back.
//  - pkt_count increments on every recv_valid; it wraps from all-ones to 0.
//  - A packet whose payload was all-zero cannot occur (the upstream stage suppresses it); no special handling.
// CONFIGURATION
//  HEADER_CHECK_EN defined:
//   - COLLECT beat whose header != latched header: the partial packet is discarded and hdr_err pulses 1 cycle.
//   - That mismatching beat is taken as beat 1 of a new packet, with the same actions as IDLE + data_valid.
//   - pkt_count is not incremented for the discarded packet.
//  HEADER_CHECK_EN undefined:
//   - Headers of beats 2..N are ignored; the header of beat 1 is delivered.
//   - hdr_err is constant 0.
// TESTING
//  1 Full packet: 1034-bit pattern with chunk k = {55{k[0]}}^k, header 9'h0A5, 19 beats -> one recv_valid at beat-19 edge, data exact, beat_cnt_recv=19, pkt_count=1.
//  2 Short packet: single beat payload 55'h1234, header 9'h003, then data_valid=0 -> recv_valid next edge, data_dfx_recv=1034'h1234, beat_cnt_recv=1.
//  3 Back-to-back: two 19-beat packets, no gap, headers 9'h011/9'h022 -> recv_valid pulses 19 cycles apart, each with the correct header and data.
//  4 Reset mid-packet: assert rst_n=0 after 7 beats -> all outputs 0; next 3-beat packet is delivered with no residue from the partial packet.
//  5 HEADER_CHECK_EN: header changes at beat 5 -> hdr_err pulse, no recv_valid for the first packet; new packet delivered. Macro off: delivered with beat-1 header.
//  6 CNT_WIDTH=2: deliver 5 one-beat packets -> pkt_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/decap_packet.sv
// decap_packet: receive-side decapsulator for the port-0 Aurora link.
// Each 64-bit link word is {payload[54:0], header[8:0]}. Payload chunks are
// reassembled LSB-first into one DATA_DFX_WIDTH word. The word is delivered
// together with the header of its first beat as a single-cycle recv_valid pulse.
// The link cannot be stalled, so a beat is accepted on every data_valid cycle.
// Optional build macro: HEADER_CHECK_EN. When it is defined, a header change
// inside a packet discards the partial packet, pulses hdr_err and starts a new
// packet with the mismatching beat.
module decap_packet #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int NUMBER_PACKET     = 19,
    parameter int HEADER_WIDTH      = 9,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - HEADER_WIDTH,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [AURORA_DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic [HEADER_WIDTH-1:0]      header_recv,
    output logic [4:0]                   beat_cnt_recv,
    output logic                         recv_valid,
    output logic                         hdr_err,
    output logic [CNT_WIDTH-1:0]         pkt_count
);

    localparam logic [4:0] LAST_SLOT = 5'(NUMBER_PACKET - 1);
    localparam logic [4:0] FULL_CNT  = 5'(NUMBER_PACKET);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic [DATA_DFX_WIDTH-1:0]  asm_r;
    logic [HEADER_WIDTH-1:0]    hdr_r;
    logic [4:0]                 beat_cnt_r;

    logic [PAYLOAD_WIDTH-1:0]   payload_s;
    logic [HEADER_WIDTH-1:0]    header_s;
    logic [DATA_DFX_WIDTH-1:0]  chunk_s;
    logic [DATA_DFX_WIDTH-1:0]  merged_s;
    logic                       hdr_mismatch_s;
    logic                       start_s;
    logic                       append_s;
    logic                       deliver_asm_s;
    logic                       deliver_merge_s;
    logic                       hdr_err_s;

    assign payload_s = data_in[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
    assign header_s  = data_in[HEADER_WIDTH-1:0];

`ifdef HEADER_CHECK_EN
    assign hdr_mismatch_s = (header_s != hdr_r);
`else
    assign hdr_mismatch_s = 1'b0;
`endif

    // Place the incoming payload at the slot of the next beat; bits past the DFX width fall off the top
    always_comb begin
        chunk_s  = DATA_DFX_WIDTH'(payload_s) << (PAYLOAD_WIDTH * 32'(beat_cnt_r));
        merged_s = asm_r | chunk_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state_s    = state_r;
        start_s         = 1'b0;
        append_s        = 1'b0;
        deliver_asm_s   = 1'b0;
        deliver_merge_s = 1'b0;
        hdr_err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (data_valid) begin
                    start_s      = 1'b1;
                    next_state_s = COLLECT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COLLECT: begin
                if (!data_valid) begin
                    deliver_asm_s = 1'b1;
                    next_state_s  = IDLE;
                end else if (hdr_mismatch_s) begin
                    hdr_err_s    = 1'b1;
                    start_s      = 1'b1;
                    next_state_s = COLLECT;
                end else if (beat_cnt_r == LAST_SLOT) begin
                    deliver_merge_s = 1'b1;
                    next_state_s    = IDLE;
                end else begin
                    append_s     = 1'b1;
                    next_state_s = COLLECT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Assembly register, latched header, beat counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_r         <= '0;
            hdr_r         <= '0;
            beat_cnt_r    <= 5'd0;
            data_dfx_recv <= '0;
            header_recv   <= '0;
            beat_cnt_recv <= 5'd0;
            recv_valid    <= 1'b0;
            hdr_err       <= 1'b0;
            pkt_count     <= '0;
        end else begin
            recv_valid <= deliver_asm_s | deliver_merge_s;
            hdr_err    <= hdr_err_s;
            if (start_s) begin
                asm_r      <= DATA_DFX_WIDTH'(payload_s);
                hdr_r      <= header_s;
                beat_cnt_r <= 5'd1;
            end else if (append_s) begin
                asm_r      <= merged_s;
                beat_cnt_r <= beat_cnt_r + 5'd1;
            end else begin
                asm_r      <= asm_r;
                beat_cnt_r <= beat_cnt_r;
            end
            if (deliver_asm_s) begin
                data_dfx_recv <= asm_r;
                header_recv   <= hdr_r;
                beat_cnt_recv <= beat_cnt_r;
                pkt_count     <= pkt_count + CNT_WIDTH'(1);
            end else if (deliver_merge_s) begin
                data_dfx_recv <= merged_s;
                header_recv   <= hdr_r;
                beat_cnt_recv <= FULL_CNT;
                pkt_count     <= pkt_count + CNT_WIDTH'(1);
            end else begin
                data_dfx_recv <= data_dfx_recv;
                header_recv   <= header_recv;
                beat_cnt_recv <= beat_cnt_recv;
                pkt_count     <= pkt_count;
            end
        end
    end

endmodule
